// File: rtl/spike_window_if.sv
// Result-record channel of the spike window counter: valid/ready plus the
// window statistics carried with each record.
interface spike_window_if #(
    parameter int CNT_W = 8
) ();
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] count_a;
    logic [CNT_W-1:0] count_b;
    logic [CNT_W-1:0] count_ab;
    logic [CNT_W-1:0] min_isi_a;
    logic             overrun;

    modport master (
        output out_valid, count_a, count_b, count_ab, min_isi_a, overrun,
        input  out_ready
    );

    modport slave (
        input  out_valid, count_a, count_b, count_ab, min_isi_a, overrun,
        output out_ready
    );
endinterface

// File: rtl/spike_window_counter.sv
// Windowed spike statistics for the LIF neuron pair: per-neuron counts,
// coincidences and minimum inter-spike interval of A, one record per window.
module spike_window_counter #(
    parameter int WIN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spike_a,
    input  logic             spike_b,
    input  logic             enable,
    input  logic [WIN_W-1:0] window_len,
    spike_window_if.master   rec
);
    localparam logic [CNT_W-1:0] CMAX    = '1;
    localparam logic [WIN_W:0]   REM_ONE = {{WIN_W{1'b0}}, 1'b1};

    typedef enum logic {IDLE, COUNT} state_t;

    state_t           state;
    logic [WIN_W:0]   rem;
    logic [CNT_W-1:0] acc_a, acc_b, acc_ab, since_a, min_a;
    logic             seen_a, lost;

    logic [CNT_W-1:0] nxt_a, nxt_b, nxt_ab, nxt_min, isi;
    logic [WIN_W:0]   load_len;
    logic             win_end, slot_free;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CMAX) ? v : v + 1'b1;
    endfunction

    // Values including the current sample, so a window end can publish them directly.
    // min_a == 0 means no interval seen yet; real intervals are always >= 1.
    always_comb begin
        nxt_a    = spike_a ? sat_inc(acc_a) : acc_a;
        nxt_b    = spike_b ? sat_inc(acc_b) : acc_b;
        nxt_ab   = (spike_a && spike_b) ? sat_inc(acc_ab) : acc_ab;
        isi      = sat_inc(since_a);
        nxt_min  = min_a;
        if (spike_a && seen_a && (min_a == '0 || isi < min_a))
            nxt_min = isi;
        load_len  = (window_len == '0) ? {1'b1, {WIN_W{1'b0}}} : {1'b0, window_len};
        win_end   = (state == COUNT) && enable && (rem == REM_ONE);
        slot_free = !rec.out_valid || rec.out_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rem           <= '0;
            acc_a         <= '0;
            acc_b         <= '0;
            acc_ab        <= '0;
            since_a       <= '0;
            min_a         <= '0;
            seen_a        <= 1'b0;
            lost          <= 1'b0;
            rec.out_valid <= 1'b0;
            rec.count_a   <= '0;
            rec.count_b   <= '0;
            rec.count_ab  <= '0;
            rec.min_isi_a <= '0;
            rec.overrun   <= 1'b0;
        end else begin
            if (win_end) begin
                if (slot_free) begin
                    rec.out_valid <= 1'b1;
                    rec.count_a   <= nxt_a;
                    rec.count_b   <= nxt_b;
                    rec.count_ab  <= nxt_ab;
                    rec.min_isi_a <= nxt_min;
                    rec.overrun   <= lost;
                    lost          <= 1'b0;
                end else begin
                    lost <= 1'b1;
                end
            end else if (rec.out_valid && rec.out_ready) begin
                rec.out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (enable) begin
                        rem   <= load_len;
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (!enable || rem == REM_ONE) begin
                        acc_a   <= '0;
                        acc_b   <= '0;
                        acc_ab  <= '0;
                        since_a <= '0;
                        min_a   <= '0;
                        seen_a  <= 1'b0;
                        if (!enable) state <= IDLE;
                        else         rem   <= load_len;
                    end else begin
                        acc_a   <= nxt_a;
                        acc_b   <= nxt_b;
                        acc_ab  <= nxt_ab;
                        min_a   <= nxt_min;
                        since_a <= spike_a ? '0 : sat_inc(since_a);
                        seen_a  <= seen_a | spike_a;
                        rem     <= rem - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spike_window_counter.sv
// Directed + randomized bench for spike_window_counter against a window-level
// reference model that recomputes each record from the stored sample list.
module tb_spike_window_counter;
    logic       clk = 1'b0;
    logic       reset, spike_a, spike_b, enable;
    logic [7:0] window_len;

    always #5 clk = ~clk;

    spike_window_if #(.CNT_W(8)) rif ();

    spike_window_counter #(.WIN_W(8), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .spike_a    (spike_a),
        .spike_b    (spike_b),
        .enable     (enable),
        .window_len (window_len),
        .rec        (rif.master)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    bit m_inwin, m_valid, m_lost, m_ovr;
    int m_n, m_ca, m_cb, m_cab, m_min;
    bit qa[$], qb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_edge();
        bit hs, done;
        int na, nb, nab, last, mn;
        hs = m_valid && rif.out_ready;
        done = 0;
        na = 0; nb = 0; nab = 0; last = -1; mn = 0;
        if (reset) begin
            m_inwin = 0; m_valid = 0; m_lost = 0; m_ovr = 0;
            m_ca = 0; m_cb = 0; m_cab = 0; m_min = 0;
            qa.delete(); qb.delete();
            return;
        end
        if (!m_inwin) begin
            if (enable) begin
                m_inwin = 1;
                m_n = (window_len == 0) ? 256 : int'(window_len);
                qa.delete(); qb.delete();
            end
        end else if (!enable) begin
            m_inwin = 0;
            qa.delete(); qb.delete();
        end else begin
            qa.push_back(spike_a);
            qb.push_back(spike_b);
            if (qa.size() == m_n) begin
                done = 1;
                foreach (qa[i]) begin
                    na += qa[i];
                    nb += qb[i];
                    nab += (qa[i] && qb[i]);
                    if (qa[i]) begin
                        if (last >= 0 && (mn == 0 || i - last < mn)) mn = i - last;
                        last = i;
                    end
                end
                qa.delete(); qb.delete();
                m_n = (window_len == 0) ? 256 : int'(window_len);
            end
        end
        if (done) begin
            if (!m_valid || hs) begin
                m_valid = 1;
                m_ca = sat(na); m_cb = sat(nb); m_cab = sat(nab); m_min = sat(mn);
                m_ovr = m_lost;
                m_lost = 0;
            end else begin
                m_lost = 1;
            end
        end else if (hs) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_all();
        chk("out_valid", rif.out_valid, m_valid);
        chk("count_a",   rif.count_a,   m_ca);
        chk("count_b",   rif.count_b,   m_cb);
        chk("count_ab",  rif.count_ab,  m_cab);
        chk("min_isi_a", rif.min_isi_a, m_min);
        chk("overrun",   rif.overrun,   m_ovr);
    endtask

    task automatic cyc(input logic sa, input logic sb, input logic en, input logic rdy,
                       input logic [7:0] wl);
        spike_a = sa; spike_b = sb; enable = en; rif.out_ready = rdy; window_len = wl;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        reset = 1'b1; spike_a = 0; spike_b = 0; enable = 0; window_len = 0; rif.out_ready = 0;

        // reset with spikes toggling
        cyc(1, 0, 1, 1, 8'd5);
        cyc(0, 1, 1, 0, 8'd5);
        chk("reset_valid", rif.out_valid, 0);
        chk("reset_count_a", rif.count_a, 0);
        reset = 1'b0;
        for (int i = 0; i < 50; i++) cyc(1'($urandom), 1'($urandom), 0, 1'($urandom), 8'd5);
        chk("idle_no_record", rif.out_valid, 0);

        // basic window: spikes on samples 1,4,7,10; start-cycle spike not counted
        cyc(1, 1, 1, 0, 8'd10);
        for (int s = 1; s <= 10; s++) cyc(s % 3 == 1, 0, 1, 0, 8'd10);
        chk("basic_valid", rif.out_valid, 1);
        chk("basic_count_a", rif.count_a, 4);
        chk("basic_min_isi", rif.min_isi_a, 3);
        chk("basic_overrun", rif.overrun, 0);
        cyc(0, 0, 0, 1, 8'd10);

        // coincidence, back-to-back windows
        cyc(1, 1, 1, 1, 8'd5);
        for (int s = 1; s <= 10; s++) begin
            cyc(1, 1, 1, 1, 8'd5);
            if (s == 5 || s == 10) begin
                chk("coinc_valid", rif.out_valid, 1);
                chk("coinc_count_ab", rif.count_ab, 5);
                chk("coinc_min_isi", rif.min_isi_a, 1);
            end
            if (s == 6) chk("coinc_gap_valid", rif.out_valid, 0);
        end
        cyc(0, 0, 0, 1, 8'd5);

        // saturation over a 256-cycle window, then a single-spike window
        cyc(1, 0, 1, 1, 8'd0);
        for (int s = 1; s <= 256; s++) cyc(1, 0, 1, 1, 8'd0);
        chk("sat_count_a", rif.count_a, 255);
        chk("sat_min_isi", rif.min_isi_a, 1);
        for (int s = 1; s <= 256; s++) cyc(s == 100, 0, 1, 1, 8'd0);
        chk("single_count_a", rif.count_a, 1);
        chk("single_min_isi", rif.min_isi_a, 0);
        cyc(0, 0, 0, 1, 8'd0);
        cyc(0, 0, 0, 1, 8'd0);

        // backpressure: two windows lost, then overrun reported once
        cyc(0, 0, 1, 0, 8'd4);
        for (int s = 1; s <= 12; s++) cyc(1'($urandom), 1'($urandom), 1, 0, 8'd4);
        for (int s = 13; s <= 16; s++) cyc(1'($urandom), 1'($urandom), 1, 1, 8'd4);
        chk("bp_overrun_set", rif.overrun, 1);
        for (int s = 17; s <= 20; s++) cyc(1'($urandom), 1'($urandom), 1, 1, 8'd4);
        chk("bp_overrun_clear", rif.overrun, 0);
        for (int s = 21; s <= 23; s++) cyc(1'($urandom), 1'($urandom), 1, 0, 8'd4);
        cyc(0, 0, 1, 1, 8'd4);
        chk("bp_coincide_valid", rif.out_valid, 1);
        chk("bp_coincide_overrun", rif.overrun, 0);
        cyc(0, 0, 0, 1, 8'd4);
        cyc(0, 0, 0, 1, 8'd4);

        // abort mid-window, then a fresh window
        cyc(1, 1, 1, 1, 8'd10);
        cyc(1, 1, 1, 1, 8'd10);
        cyc(1, 1, 1, 1, 8'd10);
        for (int i = 0; i < 12; i++) cyc(1, 1, 0, 1, 8'd10);
        chk("abort_no_record", rif.out_valid, 0);
        cyc(0, 0, 1, 0, 8'd10);
        for (int s = 1; s <= 10; s++) cyc(s == 2 || s == 5, 0, 1, 0, 8'd10);
        chk("abort_fresh_count_a", rif.count_a, 2);
        chk("abort_fresh_min_isi", rif.min_isi_a, 3);
        cyc(0, 0, 0, 1, 8'd10);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 399) == 0);
            cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 29) == 0) ? 8'd0 : 8'($urandom_range(1, 12)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spike_window_counter.md
# spike_window_counter

Windowed spike-statistics stage that sits directly downstream of the LIF neuron pair. It samples the two spike lines every cycle over a programmable window and accumulates per-neuron spike counts, a coincidence count and the minimum inter-spike interval of neuron A. At each window boundary it emits one result record through a valid/ready handshake. The record can be read out over the spare IO pins or by a host.

## Interface

Parameters:
- `WIN_W`, 8: width of `window_len`. A value of 0 means a window of 2^WIN_W cycles.
- `CNT_W`, 8: width of every count and interval output. All of them saturate.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `spike_a`  in  1  spike from the first neuron. High = one spike event this cycle.
- `spike_b`  in  1  spike from the second neuron.
- `enable`  in  1  run/stop for counting.
- `window_len`  in  WIN_W  window length in sample cycles. Latched at each window start.
- `out_ready`  in  1  consumer accepts the record.
- `out_valid`  out  1  record on the outputs is valid.
- `count_a`  out  CNT_W  cycles in the window with `spike_a` high.
- `count_b`  out  CNT_W  cycles in the window with `spike_b` high.
- `count_ab`  out  CNT_W  cycles in the window with both spikes high.
- `min_isi_a`  out  CNT_W  smallest distance in cycles between consecutive `spike_a` events in the window. 0 if there were fewer than 2 events.
- `overrun`  out  1  one or more completed windows were discarded before this record.

## Operation

- **States:** IDLE, COUNT.
- **IDLE:**
  - Accumulators are held at 0.
  - When `enable` is sampled high: latch `window_len` into `len_q`, load the remaining-cycle counter, and go to COUNT.
- **COUNT:** each cycle, sample `spike_a` and `spike_b`.
  - `acc_a` and `acc_b` increment on their spike. `acc_ab` increments when both spikes are high.
  - All three saturate at 2^CNT_W−1.
- **Interval tracking:**
  - `since_a` is cleared on each `spike_a` event and otherwise increments, saturating.
  - On every `spike_a` event after the first in the window, the interval is `since_a`+1. `min_a` takes min(`min_a`, interval).
  - Spikes in consecutive cycles give an interval of 1.
- **Window end:** the sample where remaining = 1.
  - The final accumulator values, including this sample, are copied into the output registers.
  - Accumulators, `since_a`, `min_a` and the first-spike flag are cleared.
  - If `enable` is still high, `window_len` is relatched and the next window starts on the very next cycle, with no gap. Otherwise go to IDLE.
- **`enable` low during COUNT:**
  - The partial window is discarded and the accumulators are cleared. Go to IDLE.
  - A pending output record is not affected.
- **Output register (one slot):**
  - Handshake completes when `out_valid` && `out_ready`. `out_valid` then clears, unless a new record loads in the same cycle.
  - Window end while `out_valid`=1 and no handshake in that cycle: the new result is discarded, the pending record is unchanged, and `lost` is set.
  - Window end in the same cycle as a handshake: the new record loads, `out_valid` stays 1, and there is no loss.
  - When a record loads: `overrun` takes `lost`, and `lost` clears.
  - Outputs are stable while `out_valid`=1 and `out_ready`=0.

## Timing

- **Reset:** `out_valid`, all counts, `min_isi_a` and `overrun` are 0. State is IDLE and `lost` is 0. Reset overrides every other input, including a reset asserted mid-window or mid-handshake.
- **First sample:** `enable` sampled high at edge k means the first sample is taken at edge k+1. Spikes in the cycle where `enable` first rises are not counted.
- **Window length:** N = `window_len` (or 2^WIN_W when 0) gives samples at edges k+1 … k+N. `out_valid` rises at edge k+N, with the results visible after that edge.
- **Back-to-back windows:** the next window's first sample is edge k+N+1.
- **`window_len` changes:** a change in mid-window takes effect only at the next window start.
- **Output path:** all outputs are registered, with no combinational path from inputs.

## Test plan

- **Reset:** assert `reset` for 2 cycles with spikes toggling → every output is 0 and `out_valid`=0. After release with `enable`=0, no record for 50 cycles.
- **Basic window:** `window_len`=10, `spike_a` high on samples 1, 4, 7, 10, `spike_b`=0 → one record at sample 10 with `count_a`=4, `count_b`=0, `count_ab`=0, `min_isi_a`=3, `overrun`=0.
- **Coincidence:** `window_len`=5, both spikes held high → `count_a`=`count_b`=`count_ab`=5, `min_isi_a`=1. Hold `enable` and `out_ready` high → the next record follows exactly 5 cycles later.
- **Saturation:** `window_len`=0 (256 cycles), `spike_a` held high → `count_a`=255 and `min_isi_a`=1. A single `spike_a` in the window → `min_isi_a`=0.
- **Backpressure:** `window_len`=4, `out_ready`=0 for 12 cycles → the first record is held unchanged and the next two windows are lost. After raising `out_ready`, the next loaded record has `overrun`=1 and the one after has `overrun`=0. Also check window end coinciding with a handshake → no loss.
- **Abort:** drop `enable` at sample 3 of a 10-cycle window → no record, state IDLE. Re-enable → the fresh window counts from 0 and its record reflects only the new samples.
